// File: rtl/calc_pkg.sv
// calc_pkg: shared widths, command/response codes and record types for the calculator request issuer.
package calc_pkg;
    localparam int REQ_CMD_WIDTH  = 4;
    localparam int REQ_DATA_WIDTH = 32;
    localparam int REQ_TAG_WIDTH  = 2;
    localparam int OUT_RESP_WIDTH = 2;
    typedef enum logic [REQ_CMD_WIDTH-1:0] {NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, SHL = 4'd5, SHR = 4'd6} cmd_e;
    typedef enum logic [OUT_RESP_WIDTH-1:0] {NONE = 2'd0, OK = 2'd1, ERR = 2'd2} resp_e;
    typedef enum logic [1:0] {IDLE, OP1, OP2} state_e;
    typedef logic [REQ_TAG_WIDTH-1:0] tag_t;
    typedef struct packed {
        logic [REQ_CMD_WIDTH-1:0]  cmd;
        tag_t                      tag;
        logic [OUT_RESP_WIDTH-1:0] resp;
        logic [REQ_DATA_WIDTH-1:0] data;
        logic                      timeout;
    } cpl_t;
endpackage

// File: rtl/calc_req_issuer_if.sv
// calc_req_issuer_if: transaction, DUT-port and completion signals of one issuer.
interface calc_req_issuer_if;
    import calc_pkg::*;
    logic                      txn_valid, txn_ready;
    logic [REQ_CMD_WIDTH-1:0]  txn_cmd;
    logic [REQ_DATA_WIDTH-1:0] txn_op1, txn_op2;
    logic [REQ_CMD_WIDTH-1:0]  req_cmd_out;
    logic [REQ_DATA_WIDTH-1:0] req_data_out;
    logic [REQ_TAG_WIDTH-1:0]  req_tag_out;
    logic [OUT_RESP_WIDTH-1:0] resp_in;
    logic [REQ_DATA_WIDTH-1:0] data_in;
    logic [REQ_TAG_WIDTH-1:0]  tag_in;
    logic                      cpl_valid, cpl_timeout, spurious_err;
    logic [REQ_CMD_WIDTH-1:0]  cpl_cmd;
    logic [REQ_TAG_WIDTH-1:0]  cpl_tag;
    logic [OUT_RESP_WIDTH-1:0] cpl_resp;
    logic [REQ_DATA_WIDTH-1:0] cpl_data;
    logic [2:0]                outstanding;
    modport master (
        input  txn_valid, txn_cmd, txn_op1, txn_op2, resp_in, data_in, tag_in,
        output txn_ready, req_cmd_out, req_data_out, req_tag_out, cpl_valid, cpl_cmd,
               cpl_tag, cpl_resp, cpl_data, cpl_timeout, spurious_err, outstanding
    );
    modport slave (
        output txn_valid, txn_cmd, txn_op1, txn_op2, resp_in, data_in, tag_in,
        input  txn_ready, req_cmd_out, req_data_out, req_tag_out, cpl_valid, cpl_cmd,
               cpl_tag, cpl_resp, cpl_data, cpl_timeout, spurious_err, outstanding
    );
endinterface

// File: rtl/calc_tag_table.sv
// calc_tag_table: per-tag busy/cmd/operand/timer storage with lowest-free and lowest-expired encoders.
module calc_tag_table
    import calc_pkg::*;
#(
    parameter int TIMEOUT   = 100,
    parameter int TAG_COUNT = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alloc,
    input  logic [REQ_CMD_WIDTH-1:0]  alloc_cmd,
    input  logic [REQ_DATA_WIDTH-1:0] alloc_op2,
    input  logic                      rel_en,
    input  tag_t                      rel_tag,
    input  tag_t                      op_tag,
    output logic [REQ_DATA_WIDTH-1:0] op2_rd,
    output logic [REQ_CMD_WIDTH-1:0]  cmd_rd,
    output logic [TAG_COUNT-1:0]      busy,
    output tag_t                      free_tag,
    output logic                      any_free,
    output tag_t                      exp_tag,
    output logic                      any_exp
);
    localparam int TW = $clog2(TIMEOUT);
    // Completions are registered, so expiry is flagged one count early to land TIMEOUT cycles after OP1.
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
    logic [REQ_CMD_WIDTH-1:0]  cmd_q [TAG_COUNT];
    logic [REQ_DATA_WIDTH-1:0] op2_q [TAG_COUNT];
    logic [TW-1:0]             timer [TAG_COUNT];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            for (int i = 0; i < TAG_COUNT; i++) begin
                cmd_q[i] <= '0;
                op2_q[i] <= '0;
                timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TAG_COUNT; i++) begin
                if (alloc && free_tag == tag_t'(i)) begin
                    busy[i]  <= 1'b1;
                    cmd_q[i] <= alloc_cmd;
                    op2_q[i] <= alloc_op2;
                    timer[i] <= '0;
                end else begin
                    if (rel_en && rel_tag == tag_t'(i)) busy[i] <= 1'b0;
                    if (busy[i] && timer[i] != LAST) timer[i] <= timer[i] + 1'b1;
                end
            end
        end
    end
    always_comb begin
        free_tag = '0;
        any_free = 1'b0;
        exp_tag  = '0;
        any_exp  = 1'b0;
        for (int i = TAG_COUNT - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_tag = tag_t'(i);
                any_free = 1'b1;
            end
            if (busy[i] && timer[i] == LAST) begin
                exp_tag = tag_t'(i);
                any_exp = 1'b1;
            end
        end
    end
    assign op2_rd = op2_q[op_tag];
    assign cmd_rd = cmd_q[rel_tag];
endmodule

// File: rtl/calc_req_issuer.sv
// calc_req_issuer: accepts transactions, serialises them as OP1/OP2 requests and tracks tagged responses.
module calc_req_issuer
    import calc_pkg::*;
#(
    parameter int TIMEOUT   = 100,
    parameter int TAG_COUNT = 4
) (
    input logic            ifClk,
    input logic            ifRst_n,
    calc_req_issuer_if.master bus
);
    state_e                    state, next_state;
    tag_t                      cur_tag, free_tag, exp_tag, rel_tag;
    logic [TAG_COUNT-1:0]      busy;
    logic                      any_free, any_exp, issue, resp_hit, rel_en;
    logic [REQ_CMD_WIDTH-1:0]  cmd_rd;
    logic [REQ_DATA_WIDTH-1:0] op2_rd;
    cpl_t                      cpl_q;
    calc_tag_table #(.TIMEOUT(TIMEOUT), .TAG_COUNT(TAG_COUNT)) u_tags (
        .clk(ifClk), .rst_n(ifRst_n), .alloc(issue), .alloc_cmd(bus.txn_cmd),
        .alloc_op2(bus.txn_op2), .rel_en, .rel_tag, .op_tag(cur_tag), .op2_rd, .cmd_rd,
        .busy, .free_tag, .any_free, .exp_tag, .any_exp
    );
    assign bus.txn_ready   = ifRst_n && state != OP1 && any_free;
    assign bus.outstanding = 3'($countones(busy));
    assign bus.cpl_cmd     = cpl_q.cmd;
    assign bus.cpl_tag     = cpl_q.tag;
    assign bus.cpl_resp    = cpl_q.resp;
    assign bus.cpl_data    = cpl_q.data;
    assign bus.cpl_timeout = cpl_q.timeout;
    // A no-op is handshaked but never reaches the tag table or the bus.
    always_comb begin
        issue      = bus.txn_valid && bus.txn_ready && bus.txn_cmd != NOP;
        resp_hit   = bus.resp_in != NONE && busy[bus.tag_in];
        rel_en     = resp_hit || any_exp;
        rel_tag    = resp_hit ? bus.tag_in : exp_tag;
        next_state = issue ? OP1 : state == OP1 ? OP2 : IDLE;
    end
    always_ff @(posedge ifClk or negedge ifRst_n) begin
        if (!ifRst_n) begin
            state            <= IDLE;
            cur_tag          <= '0;
            bus.req_cmd_out  <= '0;
            bus.req_data_out <= '0;
            bus.req_tag_out  <= '0;
            bus.cpl_valid    <= 1'b0;
            bus.spurious_err <= 1'b0;
            cpl_q            <= '0;
        end else begin
            state            <= next_state;
            if (issue) cur_tag <= free_tag;
            bus.req_cmd_out  <= issue ? bus.txn_cmd : '0;
            bus.req_data_out <= issue ? bus.txn_op1 : state == OP1 ? op2_rd : '0;
            bus.req_tag_out  <= issue ? free_tag : '0;
            bus.cpl_valid    <= rel_en;
            bus.spurious_err <= bus.resp_in != NONE && !busy[bus.tag_in];
            cpl_q            <= rel_en ? '{cmd: cmd_rd, tag: rel_tag,
                                           resp: resp_hit ? bus.resp_in : '0,
                                           data: resp_hit ? bus.data_in : '0,
                                           timeout: !resp_hit} : '0;
        end
    end
endmodule

// File: tb/tb_calc_req_issuer.sv
// tb_calc_req_issuer: directed cycle vectors plus reset, timeout and collision sequences.
module tb_calc_req_issuer;
    import calc_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    calc_req_issuer_if bus ();
    calc_req_issuer #(.TIMEOUT(16), .TAG_COUNT(4)) dut (.ifClk(clk), .ifRst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    typedef struct packed {
        logic        rdy;
        logic [3:0]  rc;
        logic [31:0] rd;
        logic [1:0]  rt;
        logic [2:0]  os;
        logic        cv;
        logic [3:0]  cc;
        logic [1:0]  ct;
        logic [1:0]  cr;
        logic [31:0] cd;
        logic        to;
        logic        sp;
    } obs_t;
    typedef struct packed {
        logic        v;
        logic [3:0]  c;
        logic [31:0] a, b;
        logic [1:0]  r;
        logic [31:0] d;
        logic [1:0]  t;
        obs_t        e;
    } vec_t;
    vec_t vecs [16];
    function automatic obs_t ob(logic rdy, logic [3:0] rc, logic [31:0] rd, logic [1:0] rt, logic [2:0] os,
                                logic cv = 1'b0, logic [3:0] cc = 4'd0, logic [1:0] ct = 2'd0,
                                logic [1:0] cr = 2'd0, logic [31:0] cd = 32'd0, logic to = 1'b0, logic sp = 1'b0);
        return '{rdy: rdy, rc: rc, rd: rd, rt: rt, os: os, cv: cv, cc: cc, ct: ct, cr: cr, cd: cd, to: to, sp: sp};
    endfunction
    function automatic vec_t mk(logic v, logic [3:0] c, logic [31:0] a, logic [31:0] b,
                                logic [1:0] r, logic [31:0] d, logic [1:0] t, obs_t e);
        return '{v: v, c: c, a: a, b: b, r: r, d: d, t: t, e: e};
    endfunction
    function automatic obs_t sample();
        return '{rdy: bus.txn_ready, rc: bus.req_cmd_out, rd: bus.req_data_out, rt: bus.req_tag_out,
                 os: bus.outstanding, cv: bus.cpl_valid, cc: bus.cpl_cmd, ct: bus.cpl_tag,
                 cr: bus.cpl_resp, cd: bus.cpl_data, to: bus.cpl_timeout, sp: bus.spurious_err};
    endfunction
    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask
    task automatic tick(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] r, input logic [31:0] d, input logic [1:0] t);
        @(negedge clk);
        bus.txn_valid = v;
        bus.txn_cmd   = c;
        bus.txn_op1   = a;
        bus.txn_op2   = b;
        bus.resp_in   = r;
        bus.data_in   = d;
        bus.tag_in    = t;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.txn_valid = 1'b0;
        bus.txn_cmd   = '0;
        bus.txn_op1   = '0;
        bus.txn_op2   = '0;
        bus.resp_in   = '0;
        bus.data_in   = '0;
        bus.tag_in    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    initial begin
        int n;
        int pulses;
        vecs[0]  = mk(1, 1, 5, 7, 0, 0, 0, ob(0, 1, 5, 0, 1));
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, ob(1, 0, 7, 0, 1));
        vecs[2]  = mk(0, 0, 0, 0, 1, 12, 0, ob(1, 0, 0, 0, 0, 1, 1, 0, 1, 12));
        vecs[3]  = mk(1, 0, 3, 4, 0, 0, 0, ob(1, 0, 0, 0, 0));
        vecs[4]  = mk(1, 1, 10, 20, 0, 0, 0, ob(0, 1, 10, 0, 1));
        vecs[5]  = mk(1, 2, 11, 21, 0, 0, 0, ob(1, 0, 20, 0, 1));
        vecs[6]  = mk(1, 2, 11, 21, 0, 0, 0, ob(0, 2, 11, 1, 2));
        vecs[7]  = mk(1, 2, 11, 21, 0, 0, 0, ob(1, 0, 21, 0, 2));
        vecs[8]  = mk(1, 5, 12, 3, 0, 0, 0, ob(0, 5, 12, 2, 3));
        vecs[9]  = mk(1, 5, 12, 3, 0, 0, 0, ob(1, 0, 3, 0, 3));
        vecs[10] = mk(1, 6, 13, 1, 0, 0, 0, ob(0, 6, 13, 3, 4));
        vecs[11] = mk(1, 1, 14, 2, 0, 0, 0, ob(0, 0, 1, 0, 4));
        vecs[12] = mk(1, 1, 14, 2, 0, 0, 0, ob(0, 0, 0, 0, 4));
        vecs[13] = mk(1, 1, 14, 2, 1, 15, 2, ob(1, 0, 0, 0, 3, 1, 5, 2, 1, 15));
        vecs[14] = mk(1, 1, 14, 2, 0, 0, 0, ob(0, 1, 14, 2, 4));
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, ob(0, 0, 2, 0, 4));
        do_reset();
        @(posedge clk);
        #1;
        chk("post_reset", sample(), ob(1, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++) begin
            tick(vecs[i].v, vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].d, vecs[i].t);
            chk($sformatf("vec%0d", i), sample(), vecs[i].e);
        end
        // Asynchronous reset in the OP1 cycle of add 5,7.
        do_reset();
        tick(1, 1, 5, 7, 0, 0, 0);
        chk("rst_op1", sample(), ob(0, 1, 5, 0, 1));
        #2 rst_n = 1'b0;
        #1 chk("rst_async", sample(), '0);
        bus.txn_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release", sample(), ob(1, 0, 0, 0, 0));
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("rst_no_cpl", sample(), ob(1, 0, 0, 0, 0));
        // Timeout of a lone sub and a late response on its tag.
        do_reset();
        tick(1, 2, 9, 4, 0, 0, 0);
        chk("to_op1", sample(), ob(0, 2, 9, 0, 1));
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            tick(0, 0, 0, 0, 0, 0, 0);
            if (bus.cpl_valid) begin
                n = k;
                break;
            end
        end
        chk("to_latency", 128'(n), 128'd16);
        chk("to_record", sample(), ob(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1));
        tick(0, 0, 0, 0, 1, 99, 0);
        chk("late_spurious", sample(), ob(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("spurious_clear", sample(), ob(1, 0, 0, 0, 0));
        // Response on tag 0 in the same cycle that tag 1 reaches its timeout.
        do_reset();
        tick(1, 1, 1, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        tick(1, 1, 2, 2, 0, 0, 0);
        chk("col_tag1", sample(), ob(0, 1, 2, 1, 2));
        tick(0, 0, 0, 0, 1, 2, 0);
        chk("col_cpl0", sample(), ob(1, 0, 2, 0, 1, 1, 1, 0, 1, 2));
        tick(1, 2, 8, 3, 0, 0, 0);
        chk("col_reuse0", sample(), ob(0, 2, 8, 0, 2));
        pulses = 0;
        for (int k = 5; k <= 17; k++) begin
            tick(0, 0, 0, 0, 0, 0, 0);
            if (bus.cpl_valid) pulses++;
        end
        chk("col_quiet", 128'(pulses), 128'd0);
        tick(0, 0, 0, 0, 1, 5, 0);
        chk("col_resp_wins", sample(), ob(1, 0, 0, 0, 1, 1, 2, 0, 1, 5));
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("col_timeout1", sample(), ob(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
